native_bus_decoder: RTL

NATIVE_BUS_DECODER -- requirements
Module: native_bus_decoder

---
 rtl/soc_bus_pkg.sv | 15 +
 rtl/native_bus_decoder_if.sv | 20 ++
 rtl/native_bus_addr_decode.sv | 25 ++
 rtl/native_bus_decoder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared definitions for the native (PicoRV32-style) bus decoder.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam int          DEF_N_SLAVES  = 4;
  localparam logic [31:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;
  localparam int          ERR_CNT_W     = 16;

endpackage

// File: rtl/native_bus_decoder_if.sv
// Native master bus between the core (master) and the decoder (slave).
interface native_bus_decoder_if;
  logic        m_valid;
  logic        m_instr;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic [31:0] m_rdata;

  modport master (
    output m_valid, m_instr, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_rdata
  );

  modport slave (
    input  m_valid, m_instr, m_addr, m_wdata, m_wstrb,
    output m_ready, m_rdata
  );
endinterface

// File: rtl/native_bus_addr_decode.sv
// Combinational base/mask address match; lowest-index hitting slave wins.
module native_bus_addr_decode #(
  parameter int                     N_SLAVES   = 4,
  parameter int                     SEL_W      = 2,
  parameter logic [N_SLAVES*32-1:0] SLAVE_BASE = '0,
  parameter logic [N_SLAVES*32-1:0] SLAVE_MASK = '0
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [SEL_W-1:0] sel_idx
);

  // Scan from the highest index down so the lowest hitting index is kept last.
  always_comb begin
    hit     = 1'b0;
    sel_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit     = 1'b1;
        sel_idx = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/native_bus_decoder.sv
// Native bus decoder: routes one master request to a slave, with
// unmapped-address and timeout error responses.
module native_bus_decoder
  import soc_bus_pkg::*;
#(
  parameter int                     N_SLAVES       = DEF_N_SLAVES,
  parameter logic [N_SLAVES*32-1:0] SLAVE_BASE     = {32'h3000_0000, 32'h2000_0000,
                                                      32'h1000_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*32-1:0] SLAVE_MASK     = {N_SLAVES{32'hF000_0000}},
  parameter int unsigned            TIMEOUT_CYCLES = 255,
  parameter logic [31:0]            ERR_RDATA      = DEF_ERR_RDATA
) (
  input  logic                     clk,
  input  logic                     resetn,
  native_bus_decoder_if.slave      mbus,
  output logic [N_SLAVES-1:0]      s_valid,
  output logic                     s_instr,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [N_SLAVES*32-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]      s_ready,
  output logic                     bus_err,
  output logic [31:0]              err_addr,
  output logic [ERR_CNT_W-1:0]     err_count
);

  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [31:0]            wait_q, wait_d;
  logic                   instr_q, instr_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [3:0]             wstrb_q, wstrb_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [31:0]            err_addr_q, err_addr_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic                   dec_hit;
  logic [SEL_W-1:0]       dec_sel;
  logic                   timeout_hit;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  native_bus_addr_decode #(
    .N_SLAVES   (N_SLAVES),
    .SEL_W      (SEL_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_addr_decode (
    .addr    (mbus.m_addr),
    .hit     (dec_hit),
    .sel_idx (dec_sel)
  );

  // A zero TIMEOUT_CYCLES never matches, so the slave may wait forever.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_q == TIMEOUT_CYCLES - 1);

  // Next-state logic; a ready from the selected slave beats a same-cycle timeout.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    wait_d     = wait_q;
    instr_d    = instr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mbus.m_valid) begin
          instr_d = mbus.m_instr;
          addr_d  = mbus.m_addr;
          wdata_d = mbus.m_wdata;
          wstrb_d = mbus.m_wstrb;
          wait_d  = '0;
          if (dec_hit) begin
            sel_d   = dec_sel;
            state_d = ST_BUSY;
          end else begin
            rdata_d    = ERR_RDATA;
            err_addr_d = mbus.m_addr;
            err_cnt_d  = sat_inc(err_cnt_q);
            state_d    = ST_ERR;
          end
        end
      end
      ST_BUSY: begin
        if (s_ready[sel_q]) begin
          rdata_d = s_rdata[32*sel_q +: 32];
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          rdata_d    = ERR_RDATA;
          err_addr_d = addr_q;
          err_cnt_d  = sat_inc(err_cnt_q);
          state_d    = ST_ERR;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      wait_q     <= '0;
      instr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      wait_q     <= wait_d;
      instr_q    <= instr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // One-hot slave select, only while waiting on a slave.
  always_comb begin
    s_valid = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      s_valid[i] = (state_q == ST_BUSY) && (sel_q == SEL_W'(i));
    end
  end

  assign s_instr      = instr_q;
  assign s_addr       = addr_q;
  assign s_wdata      = wdata_q;
  assign s_wstrb      = wstrb_q;
  assign mbus.m_ready = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign mbus.m_rdata = rdata_q;
  assign bus_err      = (state_q == ST_ERR);
  assign err_addr     = err_addr_q;
  assign err_count    = err_cnt_q;

endmodule
